// File: rtl/usb_rx_packet_if.sv
// Receive-side bus between the USB transceiver, the packet decoder and the endpoint logic.
// The master drives the transceiver byte stream; the slave (decoder) drives the decoded results.
interface usb_rx_packet_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_error;

    logic       token_valid;
    logic [3:0] token_pid;
    logic [6:0] token_addr;
    logic [3:0] token_endp;
    logic       token_match;
    logic       hs_valid;
    logic [3:0] hs_pid;
    logic       data_start;
    logic [3:0] data_pid;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_end;
    logic       data_ok;

    modport master (
        output rx_data, rx_valid, rx_active, rx_error,
        input  token_valid, token_pid, token_addr, token_endp, token_match,
        input  hs_valid, hs_pid, data_start, data_pid, data_out, data_out_valid,
        input  data_end, data_ok
    );

    modport slave (
        input  rx_data, rx_valid, rx_active, rx_error,
        output token_valid, token_pid, token_addr, token_endp, token_match,
        output hs_valid, hs_pid, data_start, data_pid, data_out, data_out_valid,
        output data_end, data_ok
    );
endinterface

// File: rtl/usb_rx_packet.sv
// USB receive packet decoder: PID check, token/handshake decode with CRC5, and data payload
// forwarding with CRC16 stripping and per-packet status.
module usb_rx_packet (
    input  logic            clk,
    input  logic            reset,
    input  logic [6:0]      dev_addr,
    usb_rx_packet_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_PID, S_TOK1, S_TOK2, S_TOKCHK, S_DATA, S_HSCHK, S_DISCARD
    } state_t;

    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
    localparam logic [10:0] BYTE_CNT_MAX   = 11'd1027;

    state_t      state;
    logic        act_q;
    logic        err;
    logic [4:0]  crc5;
    logic [15:0] crc16;
    logic [7:0]  tok_b1;
    logic [2:0]  tok_endp_hi;
    logic [7:0]  hold0;
    logic [7:0]  hold1;
    logic [1:0]  fill;
    logic [10:0] byte_cnt;
    logic        ovf;
    logic        rise;
    logic        fall;

    // Both CRCs shift bits in LSB first, feedback taken from the register MSB.
    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = {r[3:0], 1'b0} ^ ((d[i] ^ r[4]) ? 5'h05 : 5'h00);
        return r;
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = {r[14:0], 1'b0} ^ ((d[i] ^ r[15]) ? 16'h8005 : 16'h0000);
        return r;
    endfunction

    assign rise = bus.rx_active & ~act_q;
    assign fall = ~bus.rx_active & act_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state              <= S_IDLE;
            // A reset mid-packet must not see the still-high rx_active as a new SYNC.
            act_q              <= 1'b1;
            err                <= 1'b0;
            crc5               <= '1;
            crc16              <= '1;
            tok_b1             <= '0;
            tok_endp_hi        <= '0;
            hold0              <= '0;
            hold1              <= '0;
            fill               <= '0;
            byte_cnt           <= '0;
            ovf                <= 1'b0;
            bus.token_valid    <= 1'b0;
            bus.token_pid      <= '0;
            bus.token_addr     <= '0;
            bus.token_endp     <= '0;
            bus.token_match    <= 1'b0;
            bus.hs_valid       <= 1'b0;
            bus.hs_pid         <= '0;
            bus.data_start     <= 1'b0;
            bus.data_pid       <= '0;
            bus.data_out       <= '0;
            bus.data_out_valid <= 1'b0;
            bus.data_end       <= 1'b0;
            bus.data_ok        <= 1'b0;
        end else begin
            // NOTE: all state here is non-blocking so every read sees the pre-edge value;
            // pulse outputs default low and are raised only by the branch that fires them.
            act_q              <= bus.rx_active;
            bus.token_valid    <= 1'b0;
            bus.hs_valid       <= 1'b0;
            bus.data_start     <= 1'b0;
            bus.data_out_valid <= 1'b0;
            bus.data_end       <= 1'b0;

            if (rise) begin
                state    <= S_PID;
                err      <= 1'b0;
                crc5     <= '1;
                crc16    <= '1;
                fill     <= '0;
                byte_cnt <= '0;
                ovf      <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: ;
                    S_PID: begin
                        if (fall) begin
                            state <= S_IDLE;
                        end else if (bus.rx_error) begin
                            err   <= 1'b1;
                            state <= S_DISCARD;
                        end else if (bus.rx_valid) begin
                            if (bus.rx_data[7:4] != ~bus.rx_data[3:0]) begin
                                state <= S_DISCARD;
                            end else begin
                                unique case (bus.rx_data[3:0])
                                    4'b0001, 4'b1001, 4'b0101, 4'b1101: begin
                                        bus.token_pid <= bus.rx_data[3:0];
                                        state         <= S_TOK1;
                                    end
                                    4'b0011, 4'b1011: begin
                                        bus.data_pid   <= bus.rx_data[3:0];
                                        bus.data_start <= 1'b1;
                                        state          <= S_DATA;
                                    end
                                    4'b0010, 4'b1010, 4'b1110: begin
                                        bus.hs_pid <= bus.rx_data[3:0];
                                        state      <= S_HSCHK;
                                    end
                                    default: state <= S_DISCARD;
                                endcase
                            end
                        end
                    end
                    S_TOK1, S_TOK2: begin
                        if (fall) begin
                            state <= S_IDLE;
                        end else if (bus.rx_error) begin
                            err   <= 1'b1;
                            state <= S_DISCARD;
                        end else if (bus.rx_valid) begin
                            crc5 <= crc5_step(crc5, bus.rx_data);
                            if (state == S_TOK1) begin
                                tok_b1 <= bus.rx_data;
                                state  <= S_TOK2;
                            end else begin
                                tok_endp_hi <= bus.rx_data[2:0];
                                state       <= S_TOKCHK;
                            end
                        end
                    end
                    S_TOKCHK: begin
                        if (fall) begin
                            if (crc5 == CRC5_RESIDUAL && !err && !bus.rx_error) begin
                                bus.token_valid <= 1'b1;
                                bus.token_addr  <= tok_b1[6:0];
                                bus.token_endp  <= {tok_endp_hi, tok_b1[7]};
                                // SOF carries a frame number, not an address.
                                bus.token_match <= (bus.token_pid != 4'b0101) &&
                                                   (tok_b1[6:0] == dev_addr);
                            end
                            state <= S_IDLE;
                        end else if (bus.rx_error || bus.rx_valid) begin
                            err   <= err | bus.rx_error;
                            state <= S_DISCARD;
                        end
                    end
                    S_HSCHK: begin
                        if (fall) begin
                            bus.hs_valid <= !err && !bus.rx_error;
                            state        <= S_IDLE;
                        end else if (bus.rx_error || bus.rx_valid) begin
                            err   <= err | bus.rx_error;
                            state <= S_DISCARD;
                        end
                    end
                    S_DATA: begin
                        if (fall) begin
                            bus.data_end <= 1'b1;
                            bus.data_ok  <= (crc16 == CRC16_RESIDUAL) && (byte_cnt >= 11'd2) &&
                                            !ovf && !err && !bus.rx_error;
                            state        <= S_IDLE;
                        end else begin
                            if (bus.rx_error)
                                err <= 1'b1;
                            if (bus.rx_valid) begin
                                crc16 <= crc16_step(crc16, bus.rx_data);
                                if (byte_cnt == BYTE_CNT_MAX)
                                    ovf <= 1'b1;
                                else
                                    byte_cnt <= byte_cnt + 11'd1;
                                // Two-byte delay line keeps the trailing CRC16 off the payload port.
                                if (fill == 2'd2) begin
                                    bus.data_out       <= hold0;
                                    bus.data_out_valid <= 1'b1;
                                    hold0              <= hold1;
                                    hold1              <= bus.rx_data;
                                end else if (fill == 2'd1) begin
                                    hold1 <= bus.rx_data;
                                    fill  <= 2'd2;
                                end else begin
                                    hold0 <= bus.rx_data;
                                    fill  <= 2'd1;
                                end
                            end
                        end
                    end
                    S_DISCARD: begin
                        if (fall)
                            state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
